// File: rtl/sfp_accum.sv
// sfp_accum: special-function stage behind the psum SRAM.
// It accumulates num_taps psum vectors per output pixel. Each lane uses
// saturating signed addition. An optional ReLU is applied, and the result
// is presented with a valid/ready handshake.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous active-low reset (0 = reset)
//   start     - begin a new accumulation (sampled only in IDLE)
//   relu_en   - ReLU select, captured on an accepted start
//   in_valid  - in_data holds a psum vector
//   in_ready  - stage accepts in_data this cycle
//   in_data   - col signed lanes of psum_bw bits, lane k at [k*psum_bw +: psum_bw]
//   out_valid - sfp_out holds a finished result
//   out_ready - downstream takes sfp_out
//   sfp_out   - result vector, same lane packing as in_data
//   busy      - stage is not idle
module sfp_accum #(
  parameter int unsigned psum_bw  = 16,
  parameter int unsigned col      = 8,
  parameter int unsigned num_taps = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   busy
);

  localparam int unsigned DATA_W   = col * psum_bw;
  localparam int unsigned CNT_W    = (num_taps + 1 > 1) ? $clog2(num_taps + 1) : 1;
  localparam int unsigned LAST_TAP = num_taps - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tap_q, tap_d;
  logic              relu_q, relu_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_d;
  logic              in_ready_d, out_valid_d, busy_d;

  // Signed add at psum_bw+1 bits. The result is clamped to the lane range
  // when the two top bits disagree.
  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) begin
      sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                           : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      sat_add = s[psum_bw-1:0];
    end
  endfunction

  // ReLU zeroes a negative lane only when it was selected at start.
  function automatic logic [psum_bw-1:0] relu_lane(input logic             en,
                                                   input logic [psum_bw-1:0] v);
    relu_lane = (en && v[psum_bw-1]) ? '0 : v;
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    relu_d  = relu_q;
    acc_d   = acc_q;
    out_d   = sfp_out;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          tap_d   = '0;
          relu_d  = relu_en;
          acc_d   = '0;
        end
      end
      ACC: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < col; k++) begin
            acc_d[k*psum_bw +: psum_bw] = sat_add(acc_q[k*psum_bw +: psum_bw],
                                                  in_data[k*psum_bw +: psum_bw]);
          end
          tap_d = tap_q + CNT_W'(1);
          if (tap_q == CNT_W'(LAST_TAP)) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        for (int unsigned k = 0; k < col; k++) begin
          out_d[k*psum_bw +: psum_bw] = relu_lane(relu_q, acc_q[k*psum_bw +: psum_bw]);
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered from the next state. Each flag is
    // therefore valid in the same cycle the FSM enters the corresponding
    // state.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      relu_q    <= 1'b0;
      acc_q     <= '0;
      sfp_out   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      relu_q    <= relu_d;
      acc_q     <= acc_d;
      sfp_out   <= out_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
// Testbench for sfp_accum. It keeps a phase-level reference model that is
// compared with the DUT every cycle. Directed scenarios also carry
// hand-computed literal expectations.
module tb_sfp_accum;

  localparam int PB = 16;
  localparam int C  = 8;
  localparam int NT = 9;
  localparam int W  = PB * C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         relu_en = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sfp_out;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sfp_accum #(.psum_bw(PB), .col(C), .num_taps(NT)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .relu_en  (relu_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sfp_out  (sfp_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase;  // 0 idle, 1 accumulating, 2 finishing, 3 presenting
  int m_taps;
  bit m_relu;
  int macc[C];
  int mout[C];

  function automatic int lane(input logic [W-1:0] v, input int k);
    logic [PB-1:0] s;
    s = v[k*PB +: PB];
    return int'($signed(s));
  endfunction

  function automatic int sat(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < C; k++) v[k*PB +: PB] = PB'(mout[k]);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_taps  <= 0;
      m_relu  <= 1'b0;
      for (int k = 0; k < C; k++) begin
        macc[k] <= 0;
        mout[k] <= 0;
      end
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_taps  <= 0;
          m_relu  <= relu_en;
          for (int k = 0; k < C; k++) macc[k] <= 0;
        end
        1: if (in_valid) begin
          for (int k = 0; k < C; k++) macc[k] <= sat(macc[k] + lane(in_data, k));
          m_taps <= m_taps + 1;
          if (m_taps + 1 == NT) m_phase <= 2;
        end
        2: begin
          for (int k = 0; k < C; k++) mout[k] <= (m_relu && macc[k] < 0) ? 0 : macc[k];
          m_phase <= 3;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_lane(input string nm, input int k, input int e);
    logic [PB-1:0] ev, gv;
    ev = PB'(e);
    gv = sfp_out[k*PB +: PB];
    chk(nm, W'(gv), W'(ev));
  endtask

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready",  W'(in_ready),  W'(m_phase == 1));
      chk("m_out_valid", W'(out_valid), W'(m_phase == 3));
      chk("m_busy",      W'(busy),      W'(m_phase != 0));
      chk("m_sfp_out",   sfp_out,       model_out());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mkvec(input int l0, input int l1, input int rest);
    logic [W-1:0] v;
    for (int k = 0; k < C; k++) v[k*PB +: PB] = PB'((k == 0) ? l0 : (k == 1) ? l1 : rest);
    return v;
  endfunction

  task automatic do_start(input bit r);
    start   = 1'b1;
    relu_en = r;
    tick();
    start   = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic send_beats(input logic [W-1:0] vec, input int n, input bit stall);
    int  cnt;
    int  g;
    bit  take;
    cnt = 0;
    g   = 0;
    in_data = vec;
    while (cnt < n && g < 300) begin
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      take = in_valid && in_ready;
      tick();
      if (take) cnt++;
      g++;
    end
    in_valid = 1'b0;
    chk("beats_sent", W'(cnt), W'(n));
  endtask

  task automatic wait_out();
    int g;
    g = 0;
    while (!out_valid && g < 40) begin
      tick();
      g++;
    end
    chk("out_valid_seen", W'(out_valid), W'(1));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_busy", W'(busy), W'(0));
    chk("hs_out_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [W-1:0] cap;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sfp_out", sfp_out, W'(0));

    // Basic sum: 9 x 3 = 27 on every lane.
    do_start(1'b0);
    chk("start_busy", W'(busy), W'(1));
    chk("start_in_ready", W'(in_ready), W'(1));
    send_beats(mkvec(3, 3, 3), NT, 1'b0);
    chk("fin_out_valid", W'(out_valid), W'(0));
    chk("fin_in_ready", W'(in_ready), W'(0));
    tick();
    chk("lat_out_valid", W'(out_valid), W'(1));
    chk_lane("basic_l0", 0, 27);
    chk_lane("basic_l7", 7, 27);
    handshake();

    // ReLU and signs.
    do_start(1'b1);
    send_beats(mkvec(-5, 2, 0), NT, 1'b0);
    wait_out();
    chk_lane("relu_l0", 0, 0);
    chk_lane("relu_l1", 1, 18);
    handshake();
    do_start(1'b0);
    send_beats(mkvec(-5, 2, 0), NT, 1'b0);
    wait_out();
    chk_lane("norelu_l0", 0, -45);
    chk_lane("norelu_l1", 1, 18);
    handshake();

    // Saturation at both rails; small lanes stay exact.
    do_start(1'b0);
    send_beats(mkvec(32'sh7000, -32'sh7000, 7), NT, 1'b0);
    wait_out();
    chk_lane("sat_max", 0, 32767);
    chk_lane("sat_min", 1, -32768);
    chk_lane("sat_small", 2, 63);
    handshake();

    // Stalls on input and backpressure on output.
    do_start(1'b0);
    send_beats(mkvec(4, -4, 1), NT, 1'b1);
    wait_out();
    cap = sfp_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", sfp_out, cap);
      chk("bp_valid", W'(out_valid), W'(1));
    end
    chk_lane("bp_l0", 0, 36);
    chk_lane("bp_l1", 1, -36);
    chk_lane("bp_l5", 5, 9);
    handshake();

    // Ignored controls: in_valid in IDLE, start during ACC and OUT.
    in_valid = 1'b1;
    in_data  = mkvec(100, 100, 100);
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_busy", W'(busy), W'(0));
    do_start(1'b0);
    send_beats(mkvec(1, 1, 1), 4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beats(mkvec(1, 1, 1), NT - 4, 1'b0);
    wait_out();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("out_start_valid", W'(out_valid), W'(1));
    chk_lane("ign_l0", 0, 9);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_edge_busy", W'(busy), W'(0));
    tick();
    start = 1'b0;
    chk("restart_busy", W'(busy), W'(1));
    send_beats(mkvec(2, 2, 2), NT, 1'b0);
    wait_out();
    chk_lane("second_l0", 0, 18);
    chk_lane("second_l7", 7, 18);
    handshake();

    // Asynchronous reset mid-accumulation.
    do_start(1'b0);
    send_beats(mkvec(1, 1, 1), 4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_in_ready", W'(in_ready), W'(0));
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_sfp_out", sfp_out, W'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    do_start(1'b0);
    send_beats(mkvec(1, 1, 1), NT, 1'b0);
    wait_out();
    chk_lane("arst_run_l0", 0, 9);
    chk_lane("arst_run_l3", 3, 9);
    handshake();

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
